// File: rtl/miriscv_tb_pkg.sv
// Shared types and defaults for the miriscv test controller: FSM encoding,
// end-of-test mailbox address, hold/timeout defaults and the tohost match rule.
package miriscv_tb_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } ctrl_state_e;

  localparam int unsigned DEF_RST_CYCLES     = 10;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 40;
  localparam int unsigned DEF_CNT_W          = 32;
  localparam logic [31:0] DEF_TOHOST_ADDR    = 32'h0000_07FC;

  // Word-granular match: any byte lane of the tohost word counts; zero data is not a result.
  function automatic logic is_tohost_write(
    input logic        req,
    input logic        we,
    input logic [29:0] word_addr,
    input logic [29:0] tohost_word,
    input logic [31:0] wdata
  );
    return req & we & (word_addr == tohost_word) & (|wdata);
  endfunction

endpackage

// File: rtl/miriscv_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module miriscv_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/miriscv_test_ctrl.sv
// Test sequencer for a miriscv core: holds core reset, runs it, and ends the test
// on a tohost write (pass on 1, fail otherwise) or on a cycle budget timeout.
module miriscv_test_ctrl
  import miriscv_tb_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  output logic             core_rst_n_o,
  output logic             running_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [31:0]      tohost_o
);

  localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_next;
  logic [7:0]       r_hold_cnt;
  logic [31:0]      r_tohost;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic             w_hit;
  logic             w_run;
  logic             w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^mem_addr_i[1:0];

  assign w_run = (r_state == ST_RUN);
  assign w_hit = w_run & is_tohost_write(mem_req_i, mem_we_i, mem_addr_i[31:2],
                                         TOHOST_ADDR[31:2], mem_wdata_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
      r_tohost   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_HOLD) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
      if (w_hit) begin
        r_tohost <= mem_wdata_i;
      end
    end
  end

  // A tohost hit takes priority over the timeout on the final budget cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_hit) begin
          w_state_next = (mem_wdata_i == 32'd1) ? ST_PASS : ST_FAIL;
        end else if (w_cycle_cnt == RUN_LAST) begin
          w_state_next = ST_TIMEOUT;
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    core_rst_n_o = (r_state != ST_HOLD);
    running_o    = w_run;
    done_o       = (r_state == ST_PASS) || (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);
    pass_o       = (r_state == ST_PASS);
    timeout_o    = (r_state == ST_TIMEOUT);
  end

  miriscv_sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (w_run),
    .clr_i (r_state == ST_HOLD),
    .cnt_o (w_cycle_cnt)
  );

  assign cycle_cnt_o = w_cycle_cnt;
  assign tohost_o    = r_tohost;

endmodule

// File: tb/tb_miriscv_test_ctrl.sv
// Randomised and directed bench for miriscv_test_ctrl; expected outcome of each run
// is derived from the planned bus traffic by locating the first valid tohost write.
module tb_miriscv_test_ctrl;

  localparam int RST_C = 10;
  localparam int TO_C  = 40;
  localparam int NC    = TO_C + 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        core_rst_n, running, done, pass, tmo;
  logic [31:0] cnt, tohost;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  miriscv_test_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_req_i    (req),
    .mem_we_i     (we),
    .mem_addr_i   (addr),
    .mem_wdata_i  (wdata),
    .core_rst_n_o (core_rst_n),
    .running_o    (running),
    .done_o       (done),
    .pass_o       (pass),
    .timeout_o    (tmo),
    .cycle_cnt_o  (cnt),
    .tohost_o     (tohost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The end-of-test rule: a write of nonzero data anywhere in the tohost word.
  function automatic bit model_hit(input bit r, input bit w, input logic [31:0] a,
                                   input logic [31:0] d);
    return r && w && ((a >> 2) == (32'h0000_07FC >> 2)) && (d != 32'd0);
  endfunction

  task automatic bus_idle();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    chk({tag, " running"}, {31'd0, running}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " pass"}, {31'd0, pass}, 32'd0);
    chk({tag, " timeout"}, {31'd0, tmo}, 32'd0);
    chk({tag, " cycle_cnt"}, cnt, 32'd0);
    chk({tag, " tohost"}, tohost, 32'd0);
  endtask

  // Reset for 3 cycles, then count edges to core reset release while spraying tohost writes.
  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_idle();
    #1;
    chk_zero({name, " async_rst"});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= RST_C; k++) begin
      req = 1'b1; we = 1'b1; addr = 32'h0000_07FC;
      wdata = (k % 2 == 0) ? 32'd1 : 32'd7;
      @(posedge clk); #1;
      chk($sformatf("%s hold%0d core_rst_n", name, k), {31'd0, core_rst_n}, {31'd0, k == RST_C});
      chk($sformatf("%s hold%0d running", name, k), {31'd0, running}, {31'd0, k == RST_C});
      chk($sformatf("%s hold%0d cnt", name, k), cnt, 32'd0);
      chk($sformatf("%s hold%0d done", name, k), {31'd0, done}, 32'd0);
    end
    bus_idle();
  endtask

  task automatic run_test(input string name, input int cyc_a, input logic [31:0] d_a,
                          input int cyc_b, input logic [31:0] d_b, input bit noise,
                          input int abort_cyc);
    bit          s_req [NC];
    bit          s_we  [NC];
    logic [31:0] s_addr[NC];
    logic [31:0] s_data[NC];
    logic [31:0] tbl   [6];
    int          end_c;
    int          final_cnt;
    bit          exp_pass;
    bit          exp_to;
    logic [31:0] exp_tohost;

    tbl[0] = 32'h0000_07FC; tbl[1] = 32'h0000_07FD; tbl[2] = 32'h0000_07FF;
    tbl[3] = 32'h0000_07F8; tbl[4] = 32'h0000_0800; tbl[5] = 32'h0000_87FC;

    for (int c = 0; c < NC; c++) begin
      s_req[c] = 1'b0; s_we[c] = 1'b0; s_addr[c] = '0; s_data[c] = '0;
      if (noise && $urandom_range(0, 5) == 0) begin
        s_req[c]  = ($urandom_range(0, 3) != 0);
        s_we[c]   = ($urandom_range(0, 3) != 0);
        s_addr[c] = tbl[$urandom_range(0, 5)];
        case ($urandom_range(0, 3))
          0: s_data[c] = 32'd0;
          1: s_data[c] = 32'd1;
          2: s_data[c] = 32'd2;
          default: s_data[c] = $urandom;
        endcase
      end
      if (c == cyc_a) begin
        s_req[c] = 1'b1; s_we[c] = 1'b1; s_addr[c] = 32'h0000_07FC; s_data[c] = d_a;
      end
      if (c == cyc_b) begin
        s_req[c] = 1'b1; s_we[c] = 1'b1; s_addr[c] = 32'h0000_07FC; s_data[c] = d_b;
      end
    end
    // A passing write well after any ending must never be honoured.
    s_req[NC-3] = 1'b1; s_we[NC-3] = 1'b1; s_addr[NC-3] = 32'h0000_07FC; s_data[NC-3] = 32'd1;

    end_c = -1;
    for (int c = 0; c < TO_C; c++) begin
      if (end_c < 0 && model_hit(s_req[c], s_we[c], s_addr[c], s_data[c])) end_c = c;
    end
    final_cnt  = (end_c >= 0) ? end_c + 1 : TO_C;
    exp_to     = (end_c < 0);
    exp_pass   = (end_c >= 0) && (s_data[end_c] == 32'd1);
    exp_tohost = (end_c >= 0) ? s_data[end_c] : 32'd0;

    do_reset(name);
    for (int c = 0; c < NC; c++) begin
      bit d;
      d = (c >= final_cnt);
      chk($sformatf("%s c%0d cnt", name, c), cnt, 32'((c < final_cnt) ? c : final_cnt));
      chk($sformatf("%s c%0d running", name, c), {31'd0, running}, {31'd0, !d});
      chk($sformatf("%s c%0d done", name, c), {31'd0, done}, {31'd0, d});
      chk($sformatf("%s c%0d pass", name, c), {31'd0, pass}, {31'd0, d && exp_pass});
      chk($sformatf("%s c%0d timeout", name, c), {31'd0, tmo}, {31'd0, d && exp_to});
      chk($sformatf("%s c%0d tohost", name, c), tohost, d ? exp_tohost : 32'd0);
      chk($sformatf("%s c%0d core_rst_n", name, c), {31'd0, core_rst_n}, 32'd1);
      if (c == abort_cyc) begin
        rst = 1'b1;
        bus_idle();
        #1;
        chk_zero($sformatf("%s abort%0d", name, c));
        return;
      end
      req = s_req[c]; we = s_we[c]; addr = s_addr[c]; wdata = s_data[c];
      @(posedge clk); #1;
    end
    bus_idle();
    $display("run %s: end_cycle=%0d final_cnt=%0d pass=%0d timeout=%0d tohost=%h",
             name, end_c, final_cnt, exp_pass, exp_to, exp_tohost);
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    #2;
    chk_zero("power_on");

    run_test("pass_at_12",      12, 32'd1,     -1, 32'd0,     1'b0, -1);
    run_test("zero_then_2a",     5, 32'd0,      9, 32'h2A,    1'b0, -1);
    run_test("timeout",         -1, 32'd0,     -1, 32'd0,     1'b0, -1);
    run_test("pass_at_39",      39, 32'd1,     -1, 32'd0,     1'b0, -1);
    run_test("fail_at_39",      39, 32'hDEAD,  -1, 32'd0,     1'b0, -1);
    run_test("pass_at_0",        0, 32'd1,     -1, 32'd0,     1'b0, -1);
    run_test("abort_at_20",     -1, 32'd0,     -1, 32'd0,     1'b0, 20);
    run_test("after_abort",     15, 32'd3,     -1, 32'd0,     1'b0, -1);

    for (int i = 0; i < 18; i++) begin
      int          ca;
      int          cb;
      logic [31:0] da;
      logic [31:0] db;
      ca = $urandom_range(0, 45);
      cb = $urandom_range(0, 45);
      da = ($urandom_range(0, 2) == 0) ? 32'd1 : (($urandom_range(0, 1) == 0) ? 32'd0 : $urandom);
      db = ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom;
      run_test($sformatf("rand%0d", i), ca, da, cb, db, 1'b1,
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 30)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
